// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Access sizes, FSM states and the latched request bundle.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_BAD
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    RMW_RD,
    WR,
    RESP
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads,
// and byte/half merge into a read word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [4:0]  b_sh;
  logic [4:0]  h_sh;
  logic [31:0] b_word;
  logic [31:0] h_word;
  logic [7:0]  b;
  logic [15:0] h;

  assign b_sh   = {lane, 3'b000};
  assign h_sh   = {lane[1], 4'b0000};
  assign b_word = rdata >> b_sh;
  assign h_word = rdata >> h_sh;
  assign b      = b_word[7:0];
  assign h      = h_word[15:0];

  always_comb begin
    ld_data = rdata;
    merged  = wdata;
    unique case (size)
      SZ_B: begin
        ld_data = {{24{~is_unsigned & b[7]}}, b};
        merged  = (rdata & ~(32'h0000_00ff << b_sh))
                | ({24'h0, wdata[7:0]} << b_sh);
      end
      SZ_H: begin
        ld_data = {{16{~is_unsigned & h[15]}}, h};
        merged  = (rdata & ~(32'h0000_ffff << h_sh))
                | ({16'h0, wdata[15:0]} << h_sh);
      end
      default: begin
        ld_data = rdata;
        merged  = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit FSM: request latch, access checks and
// word-aligned memory sequencing with read-modify-write.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  import lsu_pkg::*;

  state_e      state;
  lsu_req_t    req;
  size_e       sz;
  logic        mis;
  logic        oor;
  logic        bad;
  logic        go_err;
  logic        go_ld;
  logic        go_wr;
  logic        go_rmw;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign sz        = size_e'(req_size);
  assign req_ready = (state == IDLE);

  assign mis = (sz == SZ_H && req_addr[0])
             || (sz == SZ_W && req_addr[1:0] != 2'b00);
  assign oor = req_addr[31:2] >= 30'(MEM_WORDS);
  assign bad = mis || oor || (sz == SZ_BAD);

  assign go_err = bad;
  assign go_ld  = !bad && !req_write;
  assign go_wr  = !bad && req_write && (sz == SZ_W);
  assign go_rmw = !bad && req_write && (sz != SZ_W);

  lsu_align u_align (
    .size        (req.size),
    .lane        (req.addr[1:0]),
    .is_unsigned (req.uns),
    .rdata       (mem_read_data),
    .wdata       (req.wdata),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      req            <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req       <= '{req_write, sz, req_unsigned,
                           req_addr, req_wdata};
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (!bad)
              mem_address <= {req_addr[31:2], 2'b00};
            unique case (1'b1)
              go_err: begin
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              go_ld:  state <= LD;
              go_wr: begin
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
                state          <= WR;
              end
              go_rmw: state <= RMW_RD;
              default: state <= IDLE;
            endcase
          end
        end
        LD: begin
          rsp_rdata <= ld_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          mem_write      <= 1'b1;
          mem_write_data <= merged;
          state          <= WR;
        end
        WR: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
